// File: rtl/thor2024_commit_stage.sv
// thor2024_commit_stage: two-wide in-order retirement with precise-exception handshake and flush.
// Optional retired-instruction counter enabled by THOR2024_RETIRE_CNT_EN.
module thor2024_commit_stage #(
  parameter int FLUSH_CYCLES = 2,
  parameter int EXC_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             head0_v,
  input  logic             head1_v,
  input  logic             head0_done,
  input  logic             head1_done,
  input  logic [5:0]       head0_tgt,
  input  logic [5:0]       head1_tgt,
  input  logic [63:0]      head0_val,
  input  logic [63:0]      head1_val,
  input  logic [EXC_W-1:0] head0_exc,
  input  logic [EXC_W-1:0] head1_exc,
  input  logic [63:0]      head0_pc,
  input  logic             commit_stall,
  input  logic             exc_ack,
  output logic [1:0]       head_adv,
  output logic             commit0_v,
  output logic             commit1_v,
  output logic [5:0]       commit0_tgt,
  output logic [5:0]       commit1_tgt,
  output logic [63:0]      commit0_bus,
  output logic [63:0]      commit1_bus,
  output logic             exc_v,
  output logic [EXC_W-1:0] exc_cause,
  output logic [63:0]      exc_pc,
  output logic             flush,
  output logic [63:0]      retired_cnt
);
  typedef enum logic [1:0] {RUN, EXC, DRAIN} state_t;
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  state_t        r_state, w_next;
  logic [CW-1:0] r_fcnt;
  logic          w_run, w_ok0, w_ok1, w_exc0;
  assign w_run  = r_state == RUN;
  assign w_ok0  = head0_v & head0_done & (head0_exc == '0) & !commit_stall;
  assign w_ok1  = w_ok0 & head1_v & head1_done & (head1_exc == '0);
  assign w_exc0 = head0_v & head0_done & (head0_exc != '0) & !commit_stall;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= RUN;
    else      r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_run && w_exc0)                      w_next = EXC;
    else if (r_state == EXC && exc_ack)       w_next = DRAIN;
    else if (r_state == DRAIN && r_fcnt == CW'(1)) w_next = RUN;
  end
  // Reset gating keeps the combinational advance at zero while rst is low.
  always_comb begin
    head_adv = !rst           ? 2'd0 :
               w_run          ? {w_ok1, w_ok0 & !w_ok1} :
               r_state == EXC ? {1'b0, exc_ack} : 2'd0;
    exc_v    = r_state == EXC;
    flush    = r_state == DRAIN;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      commit0_v   <= 1'b0;
      commit1_v   <= 1'b0;
      commit0_tgt <= '0;
      commit1_tgt <= '0;
      commit0_bus <= '0;
      commit1_bus <= '0;
      exc_cause   <= '0;
      exc_pc      <= '0;
      r_fcnt      <= '0;
    end else begin
      // Same-target pair: only the younger write is architecturally visible.
      commit0_v   <= w_run & w_ok0 & (head0_tgt != '0) & !(w_ok1 & (head0_tgt == head1_tgt));
      commit1_v   <= w_run & w_ok1 & (head1_tgt != '0);
      commit0_tgt <= head0_tgt;
      commit1_tgt <= head1_tgt;
      commit0_bus <= head0_val;
      commit1_bus <= head1_val;
      if (w_run && w_exc0) begin
        exc_cause <= head0_exc;
        exc_pc    <= head0_pc;
      end
      if (r_state == EXC && exc_ack) r_fcnt <= CW'(FLUSH_CYCLES);
      else if (r_state == DRAIN)     r_fcnt <= r_fcnt - CW'(1);
    end
`ifdef THOR2024_RETIRE_CNT_EN
  logic [63:0] r_retired;
  always_ff @(posedge clk or negedge rst)
    if (!rst)       r_retired <= '0;
    else if (w_run) r_retired <= r_retired + 64'(head_adv);
  assign retired_cnt = r_retired;
`else
  assign retired_cnt = '0;
`endif
endmodule

// File: tb/tb_thor2024_commit_stage.sv
// tb_thor2024_commit_stage: directed vectors with hand-computed expectations.
module tb_thor2024_commit_stage;
  logic        clk = 0, rst = 0;
  logic        head0_v = 0, head1_v = 0, head0_done = 0, head1_done = 0;
  logic [5:0]  head0_tgt = 0, head1_tgt = 0;
  logic [63:0] head0_val = 0, head1_val = 0, head0_pc = 0;
  logic [7:0]  head0_exc = 0, head1_exc = 0;
  logic        commit_stall = 0, exc_ack = 0;
  logic [1:0]  head_adv;
  logic        commit0_v, commit1_v, exc_v, flush;
  logic [5:0]  commit0_tgt, commit1_tgt;
  logic [63:0] commit0_bus, commit1_bus, exc_pc, retired_cnt;
  logic [7:0]  exc_cause;
  int n_cmp = 0, n_bad = 0;
`ifdef THOR2024_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  thor2024_commit_stage #(.FLUSH_CYCLES(2), .EXC_W(8)) dut (
    .clk(clk), .rst(rst),
    .head0_v(head0_v), .head1_v(head1_v), .head0_done(head0_done), .head1_done(head1_done),
    .head0_tgt(head0_tgt), .head1_tgt(head1_tgt), .head0_val(head0_val), .head1_val(head1_val),
    .head0_exc(head0_exc), .head1_exc(head1_exc), .head0_pc(head0_pc),
    .commit_stall(commit_stall), .exc_ack(exc_ack), .head_adv(head_adv),
    .commit0_v(commit0_v), .commit1_v(commit1_v), .commit0_tgt(commit0_tgt), .commit1_tgt(commit1_tgt),
    .commit0_bus(commit0_bus), .commit1_bus(commit1_bus), .exc_v(exc_v), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .flush(flush), .retired_cnt(retired_cnt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_h0(input logic v, input logic d, input logic [5:0] t, input logic [63:0] val, input logic [7:0] e);
    head0_v = v; head0_done = d; head0_tgt = t; head0_val = val; head0_exc = e;
  endtask

  task automatic set_h1(input logic v, input logic d, input logic [5:0] t, input logic [63:0] val, input logic [7:0] e);
    head1_v = v; head1_done = d; head1_tgt = t; head1_val = val; head1_exc = e;
  endtask

  function automatic logic [63:0] cnt(input logic [63:0] n);
    return CNT_EN ? n : 64'd0;
  endfunction

  initial begin
    #3;
    check("rst_flush", flush, 0);
    check("rst_exc_v", exc_v, 0);
    check("rst_c0v", commit0_v, 0);
    check("rst_cause", exc_cause, 0);
    check("rst_cnt", retired_cnt, 0);
    tick; rst = 1; tick;
    // dual commit
    set_h0(1, 1, 3, 64'h11, 0); set_h1(1, 1, 5, 64'h22, 0);
    #1 check("dual_adv", head_adv, 2);
    tick; set_h0(0, 0, 0, 0, 0); set_h1(0, 0, 0, 0, 0);
    check("dual_c0v", commit0_v, 1);
    check("dual_c0t", commit0_tgt, 3);
    check("dual_c0b", commit0_bus, 64'h11);
    check("dual_c1v", commit1_v, 1);
    check("dual_c1t", commit1_tgt, 5);
    check("dual_c1b", commit1_bus, 64'h22);
    check("dual_cnt", retired_cnt, cnt(2));
    // zero target, head1 not done
    set_h0(1, 1, 0, 64'h5, 0); set_h1(1, 0, 4, 64'h6, 0);
    #1 check("zt_adv", head_adv, 1);
    tick; set_h0(0, 0, 0, 0, 0); set_h1(0, 0, 0, 0, 0);
    check("zt_c0v", commit0_v, 0);
    check("zt_c1v", commit1_v, 0);
    check("zt_cnt", retired_cnt, cnt(3));
    // same target
    set_h0(1, 1, 7, 64'hA, 0); set_h1(1, 1, 7, 64'hB, 0);
    #1 check("st_adv", head_adv, 2);
    tick; set_h0(0, 0, 0, 0, 0); set_h1(0, 0, 0, 0, 0);
    check("st_c0v", commit0_v, 0);
    check("st_c1v", commit1_v, 1);
    check("st_c1b", commit1_bus, 64'hB);
    check("st_cnt", retired_cnt, cnt(5));
    #1 check("idle_adv", head_adv, 0);
    // exception on head0
    set_h0(1, 1, 9, 64'h77, 8'h2A); head0_pc = 64'h1000;
    #1 check("ex_adv0", head_adv, 0);
    tick;
    check("ex_v", exc_v, 1);
    check("ex_cause", exc_cause, 8'h2A);
    check("ex_pc", exc_pc, 64'h1000);
    check("ex_adv_hold", head_adv, 0);
    head0_pc = 64'h2000;
    tick;
    check("ex_v_hold", exc_v, 1);
    check("ex_pc_hold", exc_pc, 64'h1000);
    check("ex_c0v", commit0_v, 0);
    exc_ack = 1;
    #1 check("ex_ack_adv", head_adv, 1);
    tick; exc_ack = 0; set_h0(0, 0, 0, 0, 0); head0_pc = 0;
    check("ex_v_clr", exc_v, 0);
    check("fl_1", flush, 1);
    tick; check("fl_2", flush, 1);
    tick; check("fl_done", flush, 0);
    check("ex_cnt", retired_cnt, cnt(5));
    // stall, then head1 exception
    commit_stall = 1; set_h0(1, 1, 1, 64'h31, 0); set_h1(1, 1, 2, 64'h32, 0);
    #1 check("stl_adv", head_adv, 0);
    tick;
    check("stl_c0v", commit0_v, 0);
    check("stl_c1v", commit1_v, 0);
    commit_stall = 0; head1_exc = 8'h05;
    #1 check("h1x_adv", head_adv, 1);
    tick;
    check("h1x_c0v", commit0_v, 1);
    check("h1x_c1v", commit1_v, 0);
    check("h1x_exv0", exc_v, 0);
    set_h0(1, 1, 2, 64'h32, 8'h05); set_h1(0, 0, 0, 0, 0);
    #1 check("h1x_adv0", head_adv, 0);
    tick;
    check("h1x_exv", exc_v, 1);
    check("h1x_cause", exc_cause, 8'h05);
    check("h1x_cnt", retired_cnt, cnt(6));
    // reset mid-drain
    exc_ack = 1; tick; exc_ack = 0; set_h0(0, 0, 0, 0, 0);
    check("rd_flush", flush, 1);
    #2 rst = 0;
    #1;
    check("rd_flush0", flush, 0);
    check("rd_exv", exc_v, 0);
    check("rd_c0v", commit0_v, 0);
    check("rd_cnt", retired_cnt, 0);
    tick; rst = 1; tick;
    check("rd_run_flush", flush, 0);
    set_h0(1, 1, 4, 64'h44, 0);
    #1 check("rd_run_adv", head_adv, 1);
    tick; set_h0(0, 0, 0, 0, 0);
    check("rd_run_c0v", commit0_v, 1);
    check("rd_run_cnt", retired_cnt, cnt(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/thor2024_commit_stage.md
Name: thor2024_commit_stage

Overview:
- Two-wide in-order retirement stage between the reorder-buffer head and the architectural register file.
- Examines the two oldest ROB entries each cycle and decides how many retire (0, 1 or 2).
- Drives the register file's two commit write ports, registered, one cycle after the decision.
- Sequences precise exceptions through a small handshake/flush state machine.

Parameters:
FLUSH_CYCLES, 2, cycles flush stays asserted after an exception is acknowledged (>=1)
EXC_W, 8, exception cause width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
head0_v, head1_v  in  1  ROB head entry valid (head1 = second oldest)
head0_done, head1_done  in  1  result available
head0_tgt, head1_tgt  in  6  destination register
head0_val, head1_val  in  64 (value_t)  result
head0_exc, head1_exc  in  EXC_W  cause; 0 = none
head0_pc  in  64  PC of head0, reported on exception
commit_stall  in  1  downstream (store buffer) cannot accept retirement
exc_ack  in  1  fetch/redirect unit accepted the exception
head_adv  out  2  entries retiring this cycle; combinational; ROB advances head at next edge
commit0_v, commit1_v  out  1  register-file write enables
commit0_tgt, commit1_tgt  out  6  write addresses
commit0_bus, commit1_bus  out  64  write data
exc_v  out  1  exception pending
exc_cause  out  EXC_W  held while exc_v
exc_pc  out  64  held while exc_v
flush  out  1  pipeline flush request
retired_cnt  out  64  retired-instruction count

Behaviour:
- Reset (rst low, any time, including mid-exception): state RUN; all outputs 0; flush counter 0. Outputs reach 0 asynchronously.
- State RUN:
  - ok0 = head0_v & head0_done & head0_exc==0 & !commit_stall.
  - ok1 = ok0 & head1_v & head1_done & head1_exc==0.
  - head_adv = ok0+ok1.
  - If head0_v & head0_done & head0_exc!=0 & !commit_stall: head_adv=0; capture cause and head0_pc into exc_cause/exc_pc; next state EXC.
  - head1 exception with ok0: head0 retires alone; head1 is handled next cycle as head0.
- Commit outputs, registered, latency 1 cycle from retirement decision:
  - commitN_v <= okN & tgt!=0.
  - tgt/bus registered from head fields.
  - Retirement with tgt 0 still counts in head_adv and retired_cnt.
  - If both slots retire with equal nonzero tgt, commit0_v <= 0 (slot1 value is architecturally final).
  - commitN_v is 0 in any cycle following a non-retiring decision.
- State EXC: exc_v=1, head_adv=0, commit_v=0. On exc_ack: head_adv=1 (the faulting entry is discarded, not written), exc_v cleared next cycle, flush counter <= FLUSH_CYCLES, next state DRAIN.
- State DRAIN: flush=1, head_adv=0; counter decrements each cycle; at counter==1, next state RUN (flush low in the first RUN cycle). ROB inputs are ignored during DRAIN.
- exc_ack outside EXC: ignored.
- commit_stall: blocks all retirement and exception entry; no effect in EXC/DRAIN.
- retired_cnt:
  - Increments by head_adv each RUN cycle, wraps modulo 2^64.
  - The discarded exception entry is not counted.

Optional Feature:
THOR2024_RETIRE_CNT_EN:
- Defined: retired_cnt counter implemented as above.
- Undefined: no counter flops; retired_cnt tied to 0.

Test Plan:
- Dual commit: head0 {done, tgt 3, val 0x11}, head1 {done, tgt 5, val 0x22} -> head_adv=2 same cycle; next cycle commit0_v=1/tgt 3/0x11, commit1_v=1/tgt 5/0x22; retired_cnt +2.
- Partial/zero-target: head0 done with tgt 0, head1 not done -> head_adv=1, commit0_v=0, commit1_v=0, retired_cnt +1.
- Same target: both done, tgt 7, vals 0xA and 0xB -> commit0_v=0, commit1_v=1 with 0xB.
- Exception: head0 exc 0x2A, pc 0x1000 -> head_adv=0; exc_v=1, cause 0x2A, exc_pc 0x1000 held until exc_ack; ack cycle head_adv=1; flush high exactly 2 cycles; RUN resumes, retired_cnt unchanged.
- Stall and head1 exception: commit_stall=1 with both done -> head_adv=0, no writes; release with head1 exc=5 -> head0 retires alone, next cycle EXC with cause 5.
- Reset mid-DRAIN: rst low during flush -> flush, exc_v, commit*_v, retired_cnt 0 immediately; RUN after rst high.
